// File: rtl/sensor_trigger_scheduler_if.sv
// Trigger/config/status bundle between the timing manager, the sensor front-ends
// and the scheduler. Clock and reset stay as plain module ports.
interface sensor_trigger_scheduler_if #(
  parameter int NUM_SENSORS = 10,
  parameter int DELAY_W     = 16,
  parameter int TIMEOUT_W   = 16
);
  logic                           trigger;
  logic [NUM_SENSORS-1:0]         en_bits;
  logic [NUM_SENSORS*DELAY_W-1:0] start_delay;
  logic [TIMEOUT_W-1:0]           timeout_cycles;
  logic [NUM_SENSORS-1:0]         sensor_done;
  logic                           clear_flags;
  logic [NUM_SENSORS-1:0]         sensor_start;
  logic                           busy;
  logic                           seq_done;
  logic [NUM_SENSORS-1:0]         timeout_flags;
  logic                           overrun;

  modport master (
    output trigger, en_bits, start_delay, timeout_cycles, sensor_done, clear_flags,
    input  sensor_start, busy, seq_done, timeout_flags, overrun
  );

  modport slave (
    input  trigger, en_bits, start_delay, timeout_cycles, sensor_done, clear_flags,
    output sensor_start, busy, seq_done, timeout_flags, overrun
  );
endinterface

// File: rtl/sensor_trigger_scheduler.sv
// Fans one trigger out into per-sensor delayed start pulses, tracks each sensor's
// done edge against a shared timeout and pulses seq_done when all are resolved.
module sensor_trigger_scheduler #(
  parameter int NUM_SENSORS = 10,
  parameter int DELAY_W     = 16,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  sensor_trigger_scheduler_if.slave        bus
);
  localparam int EW = ((DELAY_W > TIMEOUT_W) ? DELAY_W : TIMEOUT_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                         state_r, state_nxt_s;
  logic [NUM_SENSORS-1:0]         en_r, en_nxt_s;
  logic [NUM_SENSORS*DELAY_W-1:0] delay_r, delay_nxt_s;
  logic [EW-1:0]                  elapsed_r, elapsed_nxt_s;
  logic [NUM_SENSORS-1:0]         started_r, started_nxt_s;
  logic [NUM_SENSORS-1:0]         pending_r, pending_nxt_s;
  logic [NUM_SENSORS-1:0]         done_d_r;
  logic [NUM_SENSORS-1:0]         start_r, start_nxt_s;
  logic [NUM_SENSORS-1:0]         flags_r, flags_nxt_s;
  logic                           busy_r, busy_nxt_s;
  logic                           seq_done_r, seq_done_nxt_s;
  logic                           overrun_r, overrun_nxt_s;
  logic [NUM_SENSORS-1:0]         rise_s, qual_s, tmo_hit_s;

  // Next-state and next-output logic for the sequencing FSM
  always_comb begin
    state_nxt_s    = state_r;
    en_nxt_s       = en_r;
    delay_nxt_s    = delay_r;
    elapsed_nxt_s  = elapsed_r;
    started_nxt_s  = started_r;
    pending_nxt_s  = pending_r;
    start_nxt_s    = '0;
    busy_nxt_s     = busy_r;
    seq_done_nxt_s = 1'b0;
    overrun_nxt_s  = overrun_r & ~bus.clear_flags;
    flags_nxt_s    = flags_r & ~{NUM_SENSORS{bus.clear_flags}};
    rise_s         = bus.sensor_done & ~done_d_r;
    qual_s         = '0;
    tmo_hit_s      = '0;
    case (state_r)
      ST_IDLE: begin
        if (bus.trigger && (bus.en_bits != '0)) begin
          state_nxt_s   = ST_RUN;
          en_nxt_s      = bus.en_bits;
          delay_nxt_s   = bus.start_delay;
          elapsed_nxt_s = '0;
          busy_nxt_s    = 1'b1;
          for (int i = 0; i < NUM_SENSORS; i++) begin
            start_nxt_s[i] = bus.en_bits[i] && (bus.start_delay[i*DELAY_W +: DELAY_W] == '0);
          end
          started_nxt_s = start_nxt_s;
          pending_nxt_s = start_nxt_s;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        overrun_nxt_s = overrun_nxt_s | bus.trigger;
        elapsed_nxt_s = (&elapsed_r) ? elapsed_r : elapsed_r + EW'(1);
        // A done edge coincident with the start pulse does not count
        qual_s = pending_r & ~start_r & rise_s;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          start_nxt_s[i] = en_r[i] && !started_r[i] &&
                           ((elapsed_r + EW'(1)) == EW'(delay_r[i*DELAY_W +: DELAY_W]));
          tmo_hit_s[i]   = pending_r[i] && !qual_s[i] && (bus.timeout_cycles != '0) &&
                           (elapsed_r >= (EW'(delay_r[i*DELAY_W +: DELAY_W]) +
                                          EW'(bus.timeout_cycles)));
        end
        started_nxt_s = started_r | start_nxt_s;
        pending_nxt_s = (pending_r & ~qual_s & ~tmo_hit_s) | start_nxt_s;
        flags_nxt_s   = flags_nxt_s | tmo_hit_s;
        // A timeout resolves once its flag is visible, so completion waits a cycle
        if (((started_nxt_s & en_r) == en_r) && (pending_nxt_s == '0) && (tmo_hit_s == '0)) begin
          state_nxt_s    = ST_DONE;
          seq_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        overrun_nxt_s = overrun_nxt_s | bus.trigger;
        state_nxt_s   = ST_IDLE;
        busy_nxt_s    = 1'b0;
        started_nxt_s = '0;
        pending_nxt_s = '0;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        busy_nxt_s    = 1'b0;
        started_nxt_s = '0;
        pending_nxt_s = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched sequence context, channel tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r       <= '0;
      delay_r    <= '0;
      elapsed_r  <= '0;
      started_r  <= '0;
      pending_r  <= '0;
      done_d_r   <= '0;
      start_r    <= '0;
      flags_r    <= '0;
      busy_r     <= 1'b0;
      seq_done_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      en_r       <= en_nxt_s;
      delay_r    <= delay_nxt_s;
      elapsed_r  <= elapsed_nxt_s;
      started_r  <= started_nxt_s;
      pending_r  <= pending_nxt_s;
      done_d_r   <= bus.sensor_done;
      start_r    <= start_nxt_s;
      flags_r    <= flags_nxt_s;
      busy_r     <= busy_nxt_s;
      seq_done_r <= seq_done_nxt_s;
      overrun_r  <= overrun_nxt_s;
    end
  end

  assign bus.sensor_start  = start_r;
  assign bus.busy          = busy_r;
  assign bus.seq_done      = seq_done_r;
  assign bus.timeout_flags = flags_r;
  assign bus.overrun       = overrun_r;
endmodule
